alu_operand_seq: RTL

Upstream sequencer for the 4-bit ALU. It accepts a serial 4-bit stream over a valid/ready handshake: opcode word, then operand A, then operand B. It holds the captured operands and opcode on registered outputs that drive the ALU, samples the ALU's combinational result and flag, and presents them on a valid/ready result port. A completed-operation counter provides debug/throughput visibility.

---
 rtl/alu_pkg.sv | 26 ++
 rtl/alu_operand_seq.sv | 92 +++++++++
 2 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the 4-bit ALU and its operand sequencer:
// default widths, opcode encodings and the sequencer state type.
package alu_pkg;

  localparam int ALU_DATA_W = 4;
  localparam int ALU_OP_W   = 3;
  localparam int SEQ_CNT_W  = 8;

  localparam logic [ALU_OP_W-1:0] OP_ADD = 3'd0;
  localparam logic [ALU_OP_W-1:0] OP_SUB = 3'd1;
  localparam logic [ALU_OP_W-1:0] OP_AND = 3'd2;
  localparam logic [ALU_OP_W-1:0] OP_OR  = 3'd3;
  localparam logic [ALU_OP_W-1:0] OP_XOR = 3'd4;
  localparam logic [ALU_OP_W-1:0] OP_EQ  = 3'd5;
  localparam logic [ALU_OP_W-1:0] OP_SHL = 3'd6;
  localparam logic [ALU_OP_W-1:0] OP_SHR = 3'd7;

  typedef enum logic [2:0] {
    S_OP   = 3'd0,
    S_A    = 3'd1,
    S_B    = 3'd2,
    S_EXEC = 3'd3,
    S_OUT  = 3'd4
  } seq_state_t;

endpackage

// File: rtl/alu_operand_seq.sv
// Operand sequencer: collects opcode, A, B from a serial stream, drives the
// sibling ALU from registers, captures its result and offers it downstream.
module alu_operand_seq
  import alu_pkg::*;
#(
  parameter int DATA_W = ALU_DATA_W,
  parameter int OP_W   = ALU_OP_W,
  parameter int CNT_W  = SEQ_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              abort,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_sel,
  input  logic [DATA_W-1:0] alu_r,
  input  logic              alu_flag,
  output logic [DATA_W-1:0] res_data,
  output logic              res_flag,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              busy,
  output logic [CNT_W-1:0]  op_count
);

  seq_state_t state, state_nxt;
  logic       beat;
  logic       consume;
  logic       unused_in_hi;

  // The opcode word only carries OP_W meaningful bits.
  assign unused_in_hi = ^in_data[DATA_W-1:OP_W];

  assign in_ready = (state == S_OP) || (state == S_A) || (state == S_B);
  assign beat     = in_valid & in_ready;
  assign consume  = res_valid & res_ready;
  assign busy     = (state != S_OP);

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      S_OP:    if (beat) state_nxt = S_A;
      S_A:     if (beat) state_nxt = S_B;
      S_B:     if (beat) state_nxt = S_EXEC;
      S_EXEC:  state_nxt = S_OUT;
      S_OUT:   if (consume) state_nxt = S_OP;
      default: state_nxt = S_OP;
    endcase
    if (abort) state_nxt = S_OP;
  end

  // NOTE: non-blocking assignments keep every register sampling pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_OP;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_sel   <= '0;
      res_data  <= '0;
      res_flag  <= 1'b0;
      res_valid <= 1'b0;
      op_count  <= '0;
    end else begin
      state <= state_nxt;
      if (abort) begin
        // Flush discards any same-cycle beat or consume; operands stay put.
        res_valid <= 1'b0;
      end else begin
        case (state)
          S_OP:   if (beat) alu_sel <= in_data[OP_W-1:0];
          S_A:    if (beat) alu_a <= in_data;
          S_B:    if (beat) alu_b <= in_data;
          S_EXEC: begin
            res_data  <= alu_r;
            res_flag  <= alu_flag;
            res_valid <= 1'b1;
          end
          S_OUT: if (consume) begin
            res_valid <= 1'b0;
            op_count  <= op_count + CNT_W'(1);
          end
          default: ;
        endcase
      end
    end
  end

endmodule
